// File: rtl/imm_gen_stage.sv
// Registered immediate generator between decode and execute: builds the extended
// immediate and PC+IMM, and presents them through a two-entry valid/ready skid buffer.
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [2:0]      IMM_SEL,
    input  logic [24:0]     IN,
    input  logic [XLEN-1:0] PC,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] OUT_IMM,
    output logic [XLEN-1:0] OUT_TARGET,
    output logic            OUT_ILLEGAL
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // Decoded immediate; the reserved code and any unknown code yield zero.
    function automatic logic [XLEN-1:0] build_imm(input logic [2:0] sel, input logic [24:0] ins);
        logic [XLEN-1:0] r;
        r = '0;
        case (sel)
            3'b000: r = sext32({ins[24:5], 12'b0});
            3'b001: r = sext32({{11{ins[24]}}, ins[24], ins[12:5], ins[13], ins[23:14], 1'b0});
            3'b010: r = sext32({{19{ins[24]}}, ins[24], ins[0], ins[23:18], ins[4:1], 1'b0});
            3'b011: r = sext32({{20{ins[24]}}, ins[24:18], ins[4:0]});
            3'b100: r = sext32({{20{ins[24]}}, ins[24:13]});
            3'b101: begin
                if (XLEN == 64) begin
                    r[5:0] = ins[18:13];
                end else begin
                    r[4:0] = ins[17:13];
                end
            end
            3'b111: r[11:0] = ins[24:13];
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t new_entry_s;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   accept_s, drain_s;

    // Result computed for the instruction currently offered upstream.
    always_comb begin
        new_entry_s         = '0;
        new_entry_s.imm     = build_imm(IMM_SEL, IN);
        new_entry_s.target  = PC + new_entry_s.imm;
        new_entry_s.illegal = (IMM_SEL == 3'b110);
    end

    // Buffer occupancy transitions and entry movement.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        accept_s = IN_VALID & in_ready_q;
        drain_s  = out_valid_q & OUT_READY;
        if (FLUSH) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_d  = new_entry_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        main_d = new_entry_s;
                    end else if (accept_s) begin
                        skid_d  = new_entry_s;
                        state_d = ST_TWO;
                    end else if (drain_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (drain_s) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Handshake flags are registered copies of the next occupancy.
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State and entry registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY    = in_ready_q;
    assign OUT_VALID   = out_valid_q;
    assign OUT_IMM     = main_q.imm;
    assign OUT_TARGET  = main_q.target;
    assign OUT_ILLEGAL = main_q.illegal;

endmodule
